// File: rtl/l1_dcache_ctrl_param.sv
// MESI tag/state controller for an N-way set-associative L1 data cache with true-LRU replacement.
// One command in flight at a time; L2 messages leave over a registered valid/ready port.
module l1_dcache_ctrl_param #(
   parameter int  ADDR_W    = 32,
   parameter int  SETS_LOG2 = 4,
   parameter int  WAYS      = 4,
   parameter int  LINE_LOG2 = 6,
   parameter int  CNT_W     = 32,
   localparam int TAG_W     = ADDR_W - SETS_LOG2 - LINE_LOG2,
   localparam int LRU_W     = $clog2(WAYS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd,
   input  logic [ADDR_W-1:0]    addr,
   output logic                 l2_valid,
   input  logic                 l2_ready,
   output logic [1:0]           l2_cmd,
   output logic [ADDR_W-1:0]    l2_addr,
   input  logic [SETS_LOG2-1:0] dbg_set,
   input  logic [LRU_W-1:0]     dbg_way,
   output logic [TAG_W-1:0]     dbg_tag,
   output logic [1:0]           dbg_mesi,
   output logic [LRU_W-1:0]     dbg_lru,
   output logic [CNT_W-1:0]     reads,
   output logic [CNT_W-1:0]     writes,
   output logic [CNT_W-1:0]     hits,
   output logic [CNT_W-1:0]     misses
);

   localparam int SETS = 1 << SETS_LOG2;

   localparam logic [2:0] CmdRead = 3'd0, CmdWrite = 3'd1, CmdSnpInv = 3'd2;
   localparam logic [2:0] CmdClear = 3'd3, CmdSnpRd = 3'd4;
   localparam logic [1:0] MesiI = 2'd0, MesiM = 2'd1, MesiS = 2'd2, MesiE = 2'd3;
   localparam logic [1:0] L2Ret = 2'd0, L2Wb = 2'd1, L2Read = 2'd2, L2Rfo = 2'd3;

   typedef enum logic [2:0] {StIdle, StLookup, StMsg1, StMsg2, StUpdate, StClr} state_e;

   state_e               state_q, state_d;
   logic [2:0]           cmd_q, cmd_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 hit_q, hit_d;
   logic [LRU_W-1:0]     way_q, way_d;
   logic [1:0]           msg2_cmd_q, msg2_cmd_d;
   logic                 l2_valid_q, l2_valid_d;
   logic [1:0]           l2_cmd_q, l2_cmd_d;
   logic [ADDR_W-1:0]    l2_addr_q, l2_addr_d;
   logic [SETS_LOG2-1:0] clr_set_q, clr_set_d;
   logic [CNT_W-1:0]     reads_q, reads_d, writes_q, writes_d;
   logic [CNT_W-1:0]     hits_q, hits_d, misses_q, misses_d;

   logic [TAG_W-1:0]     tag_q  [SETS][WAYS];
   logic [1:0]           mesi_q [SETS][WAYS];
   logic [LRU_W-1:0]     lru_q  [SETS][WAYS];

   logic [SETS_LOG2-1:0] set_idx;
   logic [TAG_W-1:0]     cur_tag;
   logic                 hit, inv_found;
   logic [LRU_W-1:0]     hit_way, vic_way, inv_way, inv_lru, old_way, old_lru;
   logic [1:0]           hit_mesi, vic_mesi, miss_cmd, upd_mesi;
   logic                 upd_install, upd_touch;

   assign set_idx  = addr_q[LINE_LOG2 +: SETS_LOG2];
   assign cur_tag  = addr_q[ADDR_W-1 -: TAG_W];
   assign hit_mesi = mesi_q[set_idx][hit_way];
   assign vic_mesi = mesi_q[set_idx][vic_way];
   assign miss_cmd = (cmd_q == CmdRead) ? L2Read : L2Rfo;

   // Hit search plus victim choice: invalid ways first, then the oldest; ties keep the lower index.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      inv_lru   = '0;
      old_way   = '0;
      old_lru   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && mesi_q[set_idx][w] != MesiI && tag_q[set_idx][w] == cur_tag) begin
            hit     = 1'b1;
            hit_way = LRU_W'(w);
         end
         if (mesi_q[set_idx][w] == MesiI && (!inv_found || lru_q[set_idx][w] > inv_lru)) begin
            inv_found = 1'b1;
            inv_way   = LRU_W'(w);
            inv_lru   = lru_q[set_idx][w];
         end
         if (w == 0 || lru_q[set_idx][w] > old_lru) begin
            old_way = LRU_W'(w);
            old_lru = lru_q[set_idx][w];
         end
      end
      vic_way = inv_found ? inv_way : old_way;
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      hit_d      = hit_q;
      way_d      = way_q;
      msg2_cmd_d = msg2_cmd_q;
      l2_valid_d = l2_valid_q;
      l2_cmd_d   = l2_cmd_q;
      l2_addr_d  = l2_addr_q;
      clr_set_d  = clr_set_q;
      reads_d    = reads_q;
      writes_d   = writes_q;
      hits_d     = hits_q;
      misses_d   = misses_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               cmd_d  = cmd;
               addr_d = addr;
               if (cmd == CmdClear) begin
                  clr_set_d = '0;
                  state_d   = StClr;
               end else begin
                  state_d = StLookup;
               end
            end
         end
         StLookup: begin
            hit_d   = hit;
            way_d   = hit ? hit_way : vic_way;
            state_d = StUpdate;
            case (cmd_q)
               CmdRead, CmdWrite: begin
                  if (cmd_q == CmdRead) reads_d = reads_q + CNT_W'(1);
                  else                  writes_d = writes_q + CNT_W'(1);
                  msg2_cmd_d = miss_cmd;
                  if (hit) begin
                     hits_d = hits_q + CNT_W'(1);
                     if (cmd_q == CmdWrite && hit_mesi == MesiS) begin
                        l2_valid_d = 1'b1;
                        l2_cmd_d   = L2Rfo;
                        l2_addr_d  = addr_q;
                        state_d    = StMsg2;
                     end
                  end else begin
                     misses_d   = misses_q + CNT_W'(1);
                     l2_valid_d = 1'b1;
                     if (vic_mesi == MesiM) begin
                        l2_cmd_d  = L2Wb;
                        l2_addr_d = {tag_q[set_idx][vic_way], set_idx, {LINE_LOG2{1'b0}}};
                        state_d   = StMsg1;
                     end else begin
                        l2_cmd_d  = miss_cmd;
                        l2_addr_d = addr_q;
                        state_d   = StMsg2;
                     end
                  end
               end
               CmdSnpRd, CmdSnpInv: begin
                  if (hit && hit_mesi == MesiM) begin
                     l2_valid_d = 1'b1;
                     l2_cmd_d   = L2Ret;
                     l2_addr_d  = addr_q;
                     state_d    = StMsg2;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
         StMsg1: begin
            if (l2_ready) begin
               l2_cmd_d  = msg2_cmd_q;
               l2_addr_d = addr_q;
               state_d   = StMsg2;
            end
         end
         StMsg2: begin
            if (l2_ready) begin
               l2_valid_d = 1'b0;
               state_d    = StUpdate;
            end
         end
         StUpdate: state_d = StIdle;
         StClr: begin
            if (&clr_set_q) state_d = StIdle;
            else            clr_set_d = clr_set_q + SETS_LOG2'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         addr_q     <= '0;
         hit_q      <= 1'b0;
         way_q      <= '0;
         msg2_cmd_q <= '0;
         l2_valid_q <= 1'b0;
         l2_cmd_q   <= '0;
         l2_addr_q  <= '0;
         clr_set_q  <= '0;
         reads_q    <= '0;
         writes_q   <= '0;
         hits_q     <= '0;
         misses_q   <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         hit_q      <= hit_d;
         way_q      <= way_d;
         msg2_cmd_q <= msg2_cmd_d;
         l2_valid_q <= l2_valid_d;
         l2_cmd_q   <= l2_cmd_d;
         l2_addr_q  <= l2_addr_d;
         clr_set_q  <= clr_set_d;
         reads_q    <= reads_d;
         writes_q   <= writes_d;
         hits_q     <= hits_d;
         misses_q   <= misses_d;
      end
   end

   // Snoops on a miss leave upd_mesi equal to the current state, so the write is a no-op.
   always_comb begin
      upd_mesi    = mesi_q[set_idx][way_q];
      upd_install = 1'b0;
      upd_touch   = 1'b0;
      case (cmd_q)
         CmdRead: begin
            upd_touch = 1'b1;
            if (!hit_q) begin
               upd_install = 1'b1;
               upd_mesi    = MesiE;
            end
         end
         CmdWrite: begin
            upd_touch   = 1'b1;
            upd_install = !hit_q;
            upd_mesi    = MesiM;
         end
         CmdSnpRd:  if (hit_q) upd_mesi = MesiS;
         CmdSnpInv: if (hit_q) upd_mesi = MesiI;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               mesi_q[s][w] <= MesiI;
               lru_q[s][w]  <= LRU_W'(WAYS - 1 - w);
            end
         end
      end else if (state_q == StClr) begin
         for (int w = 0; w < WAYS; w++) begin
            tag_q[clr_set_q][w]  <= '0;
            mesi_q[clr_set_q][w] <= MesiI;
            lru_q[clr_set_q][w]  <= LRU_W'(WAYS - 1 - w);
         end
      end else if (state_q == StUpdate) begin
         mesi_q[set_idx][way_q] <= upd_mesi;
         if (upd_install) tag_q[set_idx][way_q] <= cur_tag;
         if (upd_touch) begin
            for (int w = 0; w < WAYS; w++) begin
               if (LRU_W'(w) == way_q) lru_q[set_idx][w] <= '0;
               else if (lru_q[set_idx][w] < lru_q[set_idx][way_q])
                  lru_q[set_idx][w] <= lru_q[set_idx][w] + LRU_W'(1);
            end
         end
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign l2_valid  = l2_valid_q;
   assign l2_cmd    = l2_cmd_q;
   assign l2_addr   = l2_addr_q;
   assign dbg_tag   = tag_q[dbg_set][dbg_way];
   assign dbg_mesi  = mesi_q[dbg_set][dbg_way];
   assign dbg_lru   = lru_q[dbg_set][dbg_way];
   assign reads     = reads_q;
   assign writes    = writes_q;
   assign hits      = hits_q;
   assign misses    = misses_q;

endmodule
